// File: rtl/bram_load_sched.sv
// -----------------------------------------------------------------------------
// bram_load_sched
//
// Load scheduler between two host half-word streams (data, weight) and the
// data/weight BRAMs that feed the engine. The scheduler grants one stream at a
// time, for one burst. It packs BURST_LEN 16-bit half-words into a single
// 16*BURST_LEN-bit BRAM word and writes that word at the stream's own address.
// It counts BRAM words per stream against limits that the host programs, and
// it raises a done flag for each stream that reaches its limit. The engine is
// therefore started only on a fully loaded layer.
//
// Optional feature: define BRAM_LOAD_RR_EN for round-robin arbitration. After
// a burst, the other stream has priority if it is not done. When the macro is
// undefined, arbitration is fixed priority: data is granted before weight.
//
// Parameters
//   BURST_LEN  half-words packed per BRAM word (must be >= 2)
//   ADDR_W     BRAM address width
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle pulse. Latches the limits and zeroes the
//                       counters. Honoured only in IDLE.
//   clear               synchronous abort back to IDLE. Overrides start.
//   d_limit, w_limit    BRAM words expected per stream (0 .. 2^ADDR_W)
//   d_valid/d_data      data stream half-word in
//   d_ready             data half-word accepted when d_valid && d_ready
//   w_valid/w_data      weight stream half-word in
//   w_ready             weight half-word accepted when w_valid && w_ready
//   d_wr_en, w_wr_en    BRAM write strobe for each target (registered)
//   ram_addr, ram_data  write address and packed word shared by both targets
//   d_done, w_done      the stream has written its full limit
//   busy                high in every state except IDLE
// -----------------------------------------------------------------------------
module bram_load_sched #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      clear,
  input  logic [ADDR_W:0]           d_limit,
  input  logic [ADDR_W:0]           w_limit,
  input  logic                      d_valid,
  input  logic [15:0]               d_data,
  output logic                      d_ready,
  input  logic                      w_valid,
  input  logic [15:0]               w_data,
  output logic                      w_ready,
  output logic                      d_wr_en,
  output logic                      w_wr_en,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [16*BURST_LEN-1:0]   ram_data,
  output logic                      d_done,
  output logic                      w_done,
  output logic                      busy
);

  localparam int PACK_W = 16 * BURST_LEN;
  localparam int HW_W   = $clog2(BURST_LEN);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [HW_W-1:0] HW_LAST = HW_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_FILL,
    ST_WRITE
  } state_t;

  typedef enum logic {
    GR_D,
    GR_W
  } grant_t;

  state_t              state;
  grant_t              grant;
  grant_t              pick;
  logic [ADDR_W:0]     d_lim_q;
  logic [ADDR_W:0]     w_lim_q;
  logic [ADDR_W:0]     d_cnt;
  logic [ADDR_W:0]     w_cnt;
  logic [HW_W-1:0]     hw_cnt;
  // Holds the last BURST_LEN-1 accepted half-words, with the newest on top.
  // The half-word in flight completes the full word, so the packed word is
  // ready in the same cycle as the final accept.
  logic [PACK_W-17:0]  packer;
  logic [PACK_W-1:0]   pack_full;
  logic [15:0]         acc_data;
  logic                accept;
  logic                any_cand;

`ifdef BRAM_LOAD_RR_EN
  grant_t              last_grant;
`endif

  // Ready depends only on state and grant, so there is no combinational path
  // from valid to ready.
  assign d_ready  = (state == ST_FILL) && (grant == GR_D);
  assign w_ready  = (state == ST_FILL) && (grant == GR_W);
  assign busy     = (state != ST_IDLE);

  assign acc_data  = (grant == GR_D) ? d_data : w_data;
  assign accept    = (state == ST_FILL) && ((grant == GR_D) ? d_valid : w_valid);
  assign pack_full = {acc_data, packer};
  assign any_cand  = !d_done || !w_done;

  // Arbitration choice, used in ARB only when any_cand is set.
  // NOTE: every variable driven in always_comb gets a default first, so that
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    pick = GR_D;
`ifdef BRAM_LOAD_RR_EN
    if (!d_done && !w_done) begin
      pick = (last_grant == GR_D) ? GR_W : GR_D;
    end else if (d_done) begin
      pick = GR_W;
    end
`else
    if (d_done) begin
      pick = GR_W;
    end
`endif
  end

  // NOTE: all state in this block uses non-blocking assignments. Every
  // register therefore updates from pre-edge values, with no ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= GR_D;
      d_lim_q  <= '0;
      w_lim_q  <= '0;
      d_cnt    <= '0;
      w_cnt    <= '0;
      hw_cnt   <= '0;
      packer   <= '0;
      d_wr_en  <= 1'b0;
      w_wr_en  <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      d_done   <= 1'b0;
      w_done   <= 1'b0;
`ifdef BRAM_LOAD_RR_EN
      last_grant <= GR_W;
`endif
    end else if (clear) begin
      // Abort: drop any partial burst and forget all progress. The limits are
      // left alone; the next start latches them again.
      state   <= ST_IDLE;
      d_cnt   <= '0;
      w_cnt   <= '0;
      hw_cnt  <= '0;
      packer  <= '0;
      d_wr_en <= 1'b0;
      w_wr_en <= 1'b0;
      d_done  <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            d_lim_q <= d_limit;
            w_lim_q <= w_limit;
            d_cnt   <= '0;
            w_cnt   <= '0;
            hw_cnt  <= '0;
            packer  <= '0;
            d_done  <= (d_limit == '0);
            w_done  <= (w_limit == '0);
`ifdef BRAM_LOAD_RR_EN
            // Pretend weight went last so that data wins the first burst.
            last_grant <= GR_W;
`endif
            state   <= ST_ARB;
          end
        end

        ST_ARB: begin
          if (!any_cand) begin
            state <= ST_IDLE;
          end else begin
            grant  <= pick;
            hw_cnt <= '0;
            state  <= ST_FILL;
          end
        end

        ST_FILL: begin
          if (accept) begin
            packer <= pack_full[PACK_W-1:16];
            if (hw_cnt == HW_LAST) begin
              // Final half-word of the burst. Register the whole write, so
              // the strobe, address and word appear together in WRITE.
              hw_cnt   <= '0;
              ram_data <= pack_full;
              ram_addr <= (grant == GR_D) ? d_cnt[ADDR_W-1:0] : w_cnt[ADDR_W-1:0];
              d_wr_en  <= (grant == GR_D);
              w_wr_en  <= (grant == GR_W);
              state    <= ST_WRITE;
            end else begin
              hw_cnt <= hw_cnt + HW_W'(1);
            end
          end
        end

        ST_WRITE: begin
          d_wr_en <= 1'b0;
          w_wr_en <= 1'b0;
          hw_cnt  <= '0;
          // A done stream is never granted, so the saturation guard only
          // protects against a counter running past its limit.
          if (grant == GR_D) begin
            if (d_cnt != d_lim_q) d_cnt <= d_cnt + CNT_ONE;
            if ((d_cnt + CNT_ONE) == d_lim_q) d_done <= 1'b1;
          end else begin
            if (w_cnt != w_lim_q) w_cnt <= w_cnt + CNT_ONE;
            if ((w_cnt + CNT_ONE) == w_lim_q) w_done <= 1'b1;
          end
`ifdef BRAM_LOAD_RR_EN
          last_grant <= grant;
`endif
          state <= ST_ARB;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_load_sched.sv
// -----------------------------------------------------------------------------
// tb_bram_load_sched
//
// Self-checking bench for bram_load_sched. For each load, a stream-level model
// builds the complete list of BRAM writes the load must produce: the target,
// the address and the packed word. It builds this list from the stream
// payloads and the arbitration policy. A compare process checks every write
// strobe against that list. Hand-computed literals pin the packing layout, the
// burst timing, the write order and the boundary addresses.
// -----------------------------------------------------------------------------
module tb_bram_load_sched;

  localparam int B  = 8;
  localparam int AW = 10;
  localparam int PW = 16 * B;

  typedef struct {
    bit              is_w;
    int              addr;
    logic [PW-1:0]   word;
  } wr_t;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            clear;
  logic [AW:0]     d_limit;
  logic [AW:0]     w_limit;
  logic            d_valid;
  logic [15:0]     d_data;
  logic            d_ready;
  logic            w_valid;
  logic [15:0]     w_data;
  logic            w_ready;
  logic            d_wr_en;
  logic            w_wr_en;
  logic [AW-1:0]   ram_addr;
  logic [PW-1:0]   ram_data;
  logic            d_done;
  logic            w_done;
  logic            busy;

  int              n_tests = 0;
  int              n_fail  = 0;
  bit              toggle  = 0;

  logic [15:0]     d_src[$];
  logic [15:0]     w_src[$];
  logic [15:0]     d_pay[$];
  logic [15:0]     w_pay[$];
  wr_t             exp_q[$];
  wr_t             log_q[$];

  bram_load_sched #(.BURST_LEN(B), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clear    (clear),
    .d_limit  (d_limit),
    .w_limit  (w_limit),
    .d_valid  (d_valid),
    .d_data   (d_data),
    .d_ready  (d_ready),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_ready  (w_ready),
    .d_wr_en  (d_wr_en),
    .w_wr_en  (w_wr_en),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .d_done   (d_done),
    .w_done   (w_done),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stream-level model: the ordered list of writes for one complete load.
  task automatic build_expect(input int dl, input int wl);
    int di = 0;
    int wi = 0;
    bit last_w = 1'b1;
    bit pick_w;
    wr_t e;
    while (di < dl || wi < wl) begin
`ifdef BRAM_LOAD_RR_EN
      if (di < dl && wi < wl) pick_w = !last_w;
      else                    pick_w = (wi < wl);
`else
      pick_w = !(di < dl);
`endif
      e.is_w = pick_w;
      e.addr = pick_w ? wi : di;
      for (int i = 0; i < B; i++)
        e.word[16*i +: 16] = pick_w ? w_pay[wi*B + i] : d_pay[di*B + i];
      exp_q.push_back(e);
      if (pick_w) wi++; else di++;
      last_w = pick_w;
    end
  endtask

  // Upstream sources. Valid is presented while data is queued; in toggle mode,
  // valid is presented only every other cycle. A handshake observed in one
  // cycle pops the queue at the start of the next cycle.
  initial begin
    bit d_hs = 1'b0;
    bit w_hs = 1'b0;
    bit phase = 1'b0;
    d_valid = 1'b0; d_data = '0;
    w_valid = 1'b0; w_data = '0;
    forever begin
      @(negedge clk);
      if (d_hs && d_src.size() > 0) void'(d_src.pop_front());
      if (w_hs && w_src.size() > 0) void'(w_src.pop_front());
      phase   = !phase;
      d_valid = (d_src.size() > 0) && (!toggle || phase);
      d_data  = (d_src.size() > 0) ? d_src[0] : 16'h0;
      w_valid = (w_src.size() > 0);
      w_data  = (w_src.size() > 0) ? w_src[0] : 16'h0;
      d_hs    = d_valid && d_ready;
      w_hs    = w_valid && w_ready;
    end
  end

  // Compare process: checks every write strobe against the model and checks
  // the handshake invariants on every cycle.
  initial begin
    bit  prev_wr = 1'b0;
    wr_t got;
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wr = 1'b0;
      end else begin
        if (d_ready || w_ready) check("ready_exclusive", d_ready && w_ready, 0);
        if (d_done) check("d_ready_after_done", d_ready, 0);
        if (w_done) check("w_ready_after_done", w_ready, 0);
        if (d_wr_en || w_wr_en) begin
          check("single_strobe", d_wr_en && w_wr_en, 0);
          check("strobe_one_cycle", prev_wr, 0);
          got.is_w = w_wr_en;
          got.addr = int'(ram_addr);
          got.word = ram_data;
          log_q.push_back(got);
          check("write_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_target", got.is_w, e.is_w);
            check("wr_addr", got.addr, e.addr);
            check("wr_data", got.word, e.word);
          end
        end
        prev_wr = d_wr_en || w_wr_en;
      end
    end
  end

  // One complete load. cyc returns the number of cycles busy was high. If
  // restart is set, a start pulse with different limits is issued mid-load.
  task automatic run_load(input int dl, input int wl, input logic [15:0] dbase,
                          input logic [15:0] wbase, input bit restart, output int cyc);
    log_q.delete();
    exp_q.delete();
    d_pay.delete();
    w_pay.delete();
    for (int i = 0; i < dl*B; i++) d_pay.push_back(dbase + 16'(i));
    for (int i = 0; i < wl*B; i++) w_pay.push_back(wbase + 16'(i));
    d_src = d_pay;
    w_src = w_pay;
    build_expect(dl, wl);
    @(negedge clk);
    d_limit = (AW+1)'(dl);
    w_limit = (AW+1)'(wl);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 20000) begin
      if (restart && cyc == 4) begin
        start   = 1'b1;
        d_limit = 5;
        w_limit = 0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("load_busy_timeout", busy, 0);
    check("load_all_written", exp_q.size(), 0);
    check("load_d_done", d_done, 1);
    check("load_w_done", w_done, 1);
  endtask

  initial begin
    int cyc;
    logic [3:0] ord;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; d_limit = '0; w_limit = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", {d_ready, w_ready}, 0);
    check("rst_wr_en", {d_wr_en, w_wr_en}, 0);
    check("rst_done", {d_done, w_done}, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    rst_n = 1'b1;

    // Two data words, no weight: the packing layout and the burst timing.
    run_load(2, 0, 16'h0001, 16'h0000, 1'b0, cyc);
    check("t1_busy_cycles", cyc, 21);
    check("t1_writes", log_q.size(), 2);
    check("t1_w0_addr", log_q[0].addr, 0);
    check("t1_w0_lo", log_q[0].word[15:0], 16'h0001);
    check("t1_w0_hi", log_q[0].word[127:112], 16'h0008);
    check("t1_w1_addr", log_q[1].addr, 1);
    check("t1_w1_lo", log_q[1].word[15:0], 16'h0009);
    check("t1_w1_hi", log_q[1].word[127:112], 16'h0010);

    // Both limits zero: straight back to IDLE.
    run_load(0, 0, 16'h0, 16'h0, 1'b0, cyc);
    check("zero_busy_cycles", cyc, 1);
    check("zero_writes", log_q.size(), 0);

    // Both streams: the write order depends on the policy.
    run_load(2, 2, 16'h1000, 16'h2000, 1'b0, cyc);
    ord = '0;
    foreach (log_q[i]) ord = {ord[2:0], log_q[i].is_w};
    check("both_writes", log_q.size(), 4);
`ifdef BRAM_LOAD_RR_EN
    check("both_order", ord, 4'b0101);
`else
    check("both_order", ord, 4'b0011);
`endif

    // Valid toggling: same words, slower.
    toggle = 1'b1;
    run_load(2, 0, 16'h3000, 16'h0, 1'b0, cyc);
    toggle = 1'b0;
    check("toggle_slower", cyc >= 34, 1);

    // Clear after 5 accepted half-words.
    log_q.delete(); exp_q.delete(); d_src.delete(); w_src.delete();
    for (int i = 0; i < 5; i++) d_src.push_back(16'h4000 + 16'(i));
    @(negedge clk);
    d_limit = 2; w_limit = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (d_src.size() > 0 && cyc < 100) begin @(negedge clk); cyc++; end
    check("clr_feed_timeout", d_src.size(), 0);
    repeat (2) @(negedge clk);
    check("clr_still_fill", d_ready, 1);
    check("clr_w_done_before", w_done, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_done", {d_done, w_done}, 0);
    repeat (3) @(negedge clk);
    check("clr_no_write", log_q.size(), 0);
    run_load(1, 0, 16'h5000, 16'h0, 1'b0, cyc);
    check("clr_restart_writes", log_q.size(), 1);
    check("clr_restart_addr", log_q[0].addr, 0);

    // Reset asserted mid-FILL.
    log_q.delete(); exp_q.delete(); d_src.delete(); w_src.delete();
    for (int i = 0; i < 3; i++) d_src.push_back(16'h6000 + 16'(i));
    @(negedge clk);
    d_limit = 2; w_limit = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (d_src.size() > 0 && cyc < 100) begin @(negedge clk); cyc++; end
    check("mrst_feed_timeout", d_src.size(), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_ready", {d_ready, w_ready}, 0);
    check("mrst_wr_en", {d_wr_en, w_wr_en}, 0);
    check("mrst_done", {d_done, w_done}, 0);
    check("mrst_addr", ram_addr, 0);
    check("mrst_data", ram_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // A start while busy is ignored: the original limits (1,1) still apply.
    run_load(1, 1, 16'h7000, 16'h8000, 1'b1, cyc);
    check("rstart_writes", log_q.size(), 2);

    // Full-depth data load: the last write lands at the top address.
    run_load(1024, 0, 16'hA5A0, 16'h0, 1'b0, cyc);
    check("deep_writes", log_q.size(), 1024);
    check("deep_last_addr", log_q[log_q.size()-1].addr, 'h3FF);
    check("deep_no_ready", d_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_load_sched.md
# bram_load_sched

Load scheduler between the host block-throttled pipe endpoints and the data/weight BRAMs feeding the engine. Accepts two independent 16-bit half-word streams (data, weight), arbitrates between them at burst granularity, packs `BURST_LEN` half-words into one `16*BURST_LEN`-bit BRAM word and issues the write with a per-stream address. Tracks per-stream word counts against host-programmed limits and reports completion so the engine is started only on a fully loaded layer.

## Interface
- `BURST_LEN`, 8, half-words packed per BRAM word
- `ADDR_W`, 10, BRAM address width
- `clk` in 1, single clock for all logic
- `rst_n` in 1, synchronous, active-low reset
- `start` in 1, one-cycle pulse; samples limits, zeroes counters; honored only in IDLE
- `clear` in 1, synchronous abort; returns to IDLE from any state
- `d_limit`, `w_limit` in ADDR_W+1, BRAM words expected per stream (0 … 2^ADDR_W)
- `d_valid`, `w_valid` in 1, half-word available
- `d_data`, `w_data` in 16, half-word payload
- `d_ready`, `w_ready` out 1, half-word accepted when valid && ready
- `d_wr_en`, `w_wr_en` out 1, BRAM write strobe per target
- `ram_addr` out ADDR_W, write address (shared by both targets)
- `ram_data` out 16*BURST_LEN, packed write word
- `d_done`, `w_done` out 1, stream reached its limit
- `busy` out 1, high in any state except IDLE

## Operation
- States: IDLE, ARB, FILL, WRITE.
- IDLE: `start` → latch limits, zero `d_cnt`/`w_cnt`, `hw_cnt`, packer; set `d_done`=(d_limit==0), `w_done`=(w_limit==0); go ARB. Other inputs ignored.
- ARB: candidates = streams not done. None → IDLE. Else grant one per arbitration policy (Configuration), go FILL. Valid is not required to win grant; grant holds until burst completes.
- FILL: ready asserted only for granted stream. Each accept: packer ← {data, packer[16*BURST_LEN-1:16]}, `hw_cnt`++. First accepted half-word ends in bits [15:0]. Accept of half-word `BURST_LEN` → WRITE.
- WRITE: one cycle; granted target's wr_en=1, `ram_addr`=granted counter, `ram_data`=packer. Counter++; if counter+1==limit set that done flag. `hw_cnt`←0; go ARB.
- Counters saturate at limit; no address wrap-around. Limit 2^ADDR_W writes address 2^ADDR_W−1 last.
- Partial bursts never written; stream length must be a multiple of `BURST_LEN` half-words.
- `clear` (any state): → IDLE, partial burst discarded, counters zeroed, done flags cleared, no write issued that cycle. `clear` dominates `start`.
- Done flags hold until next `start`, `clear` or reset.

## Timing
- Reset (`rst_n`=0 at edge): state IDLE; all ready, wr_en, done, busy = 0; `ram_addr`=0; `ram_data`=0.
- ready is combinational from state/grant only (no valid→ready path); wr_en, `ram_addr`, `ram_data` registered.
- wr_en asserted the cycle after the final half-word accept; exactly one cycle.
- Per burst: `BURST_LEN` accept cycles + WRITE + ARB; minimum 10 cycles at BURST_LEN=8 with continuous valid.
- `busy` rises the cycle after `start`; falls the cycle after ARB finds no candidate.
- Ready deasserted in ARB/WRITE/IDLE; upstream holds data under back-pressure.

## Configuration
- `BRAM_LOAD_RR_EN` defined: round-robin; after a burst the other stream has priority if not done.
- Undefined: fixed priority, data before weight; weight granted only when data done.
- Both: done stream never granted; single remaining stream granted back-to-back.

## Test plan
- d_limit=2, w_limit=0, 16 data half-words 0x0001..0x0010 → d_wr_en at addr 0 with data[15:0]=0x0001, [127:112]=0x0008; addr 1 with 0x0009..0x0010; d_done=1, w_done=1, busy falls.
- RR_EN defined, both limits=2, both valid continuously → write order d0, w0, d1, w1; undefined → d0, d1, w0, w1.
- Data valid toggling every other cycle → accepts only on valid&&ready, packed word unchanged, write delayed accordingly.
- `clear` after 5 accepted half-words → no write, busy=0 next cycle, counters/done zero; new `start` restarts at addr 0.
- `rst_n` low mid-FILL → all outputs at reset values next cycle; `start` while busy → ignored, limits unchanged.
- d_limit=1024 (ADDR_W=10) → last write addr 0x3FF, d_done set, no further d_ready.
